// File: rtl/conv_multi_thread_l1.sv
`default_nettype none
// ============================================================================
// Module      : conv_multi_thread_l1
// Description : THREAD-wide first-layer convolution with a double-buffered,
//               serially loaded weight bank and a fixed 4-stage pipeline.
// Revision    : 1.0
// ============================================================================
module conv_multi_thread_l1 #(
    parameter int WIDTH_D = 8,
    parameter int CH      = 3,
    parameter int LEN     = 7,
    parameter int WIDTH_W = 20,
    parameter int WIDTH_C = 27,
    parameter int THREAD  = 4,
    parameter int QUANT_D = 5,
    parameter int RELU_EN = 1
) (
    input  logic                            i_sclk,
    input  logic                            i_rst_n,
    input  logic                            i_vsync,
    input  logic                            i_hsync,
    input  logic                            i_reuse,
    input  logic                            i_valid,
    input  logic [WIDTH_D*CH*LEN*LEN-1:0]   i_tdata,
    input  logic                            i_cw_vld,
    input  logic [WIDTH_W-1:0]              i_cw,
    output logic                            o_cw_rdy,
    output logic                            o_vsync,
    output logic                            o_hsync,
    output logic                            o_reuse,
    output logic                            o_valid,
    output logic [WIDTH_C*THREAD-1:0]       o_tdata
);

    localparam int NK      = CH * LEN * LEN;
    localparam int NW      = THREAD * NK;
    localparam int CW      = (NW > 1) ? $clog2(NW) : 1;
    localparam int WIDTH_P = WIDTH_D + WIDTH_W + 1;
    localparam int WIDTH_S = WIDTH_P + $clog2(NK) + 1;
    // Accumulator is at least one bit wider than the output so saturation can see overflow.
    localparam int WIDTH_A = (WIDTH_S > WIDTH_C + 1) ? WIDTH_S : WIDTH_C + 1;

    localparam logic [CW-1:0]             C_LAST = CW'(NW - 1);
    localparam logic signed [WIDTH_A-1:0] C_MAX  = {{(WIDTH_A-WIDTH_C+1){1'b0}}, {(WIDTH_C-1){1'b1}}};
    localparam logic signed [WIDTH_A-1:0] C_MIN  = {{(WIDTH_A-WIDTH_C+1){1'b1}}, {(WIDTH_C-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      vsync_q, vsync_d;
    logic signed [WIDTH_W-1:0] shadow_q [NW];
    logic signed [WIDTH_W-1:0] shadow_d [NW];
    logic signed [WIDTH_W-1:0] active_q [NW];
    logic signed [WIDTH_W-1:0] active_d [NW];

    logic [WIDTH_D*NK-1:0]     pix_q, pix_d;
    logic [3:0]                sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d, sb4_q, sb4_d;
    logic signed [WIDTH_P-1:0] prod_q [THREAD][NK];
    logic signed [WIDTH_P-1:0] prod_d [THREAD][NK];
    logic signed [WIDTH_A-1:0] acc_q  [THREAD];
    logic signed [WIDTH_A-1:0] acc_d  [THREAD];
    logic [WIDTH_C*THREAD-1:0] tdata_q, tdata_d;

    // ------------------------------------------------------------------
    // Weight loader: fill shadow bank, then wait for a frame start to swap
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vsync_d  = i_vsync;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            ST_LOAD: begin
                if (i_cw_vld) begin
                    shadow_d[cnt_q] = i_cw;
                    if (cnt_q == C_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_FULL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (i_vsync && !vsync_q) begin
                    active_d = shadow_q;
                    state_d  = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: S1 capture, S2 multiply, S3 reduce, S4 quantise/clip
    // ------------------------------------------------------------------
    always_comb begin : dp_comb
        logic signed [WIDTH_P-1:0] px_ext;
        logic signed [WIDTH_P-1:0] w_ext;
        logic signed [WIDTH_A-1:0] sh;
        logic signed [WIDTH_C-1:0] res;
        px_ext  = '0;
        w_ext   = '0;
        sh      = '0;
        res     = '0;
        pix_d   = i_tdata;
        sb1_d   = {i_vsync, i_hsync, i_reuse, i_valid};
        sb2_d   = sb1_q;
        sb3_d   = sb2_q;
        sb4_d   = sb3_q;
        tdata_d = tdata_q;
        for (int t = 0; t < THREAD; t++) begin
            for (int k = 0; k < NK; k++) begin
                px_ext        = WIDTH_P'($signed({1'b0, pix_q[WIDTH_D*k +: WIDTH_D]}));
                w_ext         = WIDTH_P'(active_q[t*NK + k]);
                prod_d[t][k]  = px_ext * w_ext;
            end
        end
        for (int t = 0; t < THREAD; t++) begin
            acc_d[t] = '0;
            for (int k = 0; k < NK; k++) begin
                acc_d[t] = acc_d[t] + WIDTH_A'(prod_q[t][k]);
            end
        end
        for (int t = 0; t < THREAD; t++) begin
            sh = acc_q[t] >>> QUANT_D;
            if (sh > C_MAX) begin
                res = C_MAX[WIDTH_C-1:0];
            end else if (sh < C_MIN) begin
                res = C_MIN[WIDTH_C-1:0];
            end else begin
                res = sh[WIDTH_C-1:0];
            end
            if ((RELU_EN != 0) && res[WIDTH_C-1]) begin
                res = '0;
            end
            if (sb3_q[0]) begin
                tdata_d[WIDTH_C*t +: WIDTH_C] = res;
            end
        end
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pix_q   <= '0;
            sb1_q   <= '0;
            sb2_q   <= '0;
            sb3_q   <= '0;
            sb4_q   <= '0;
            for (int t = 0; t < THREAD; t++) begin
                acc_q[t] <= '0;
                for (int k = 0; k < NK; k++) begin
                    prod_q[t][k] <= '0;
                end
            end
            tdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vsync_q  <= vsync_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pix_q    <= pix_d;
            sb1_q    <= sb1_d;
            sb2_q    <= sb2_d;
            sb3_q    <= sb3_d;
            sb4_q    <= sb4_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
        end
    end

    assign o_cw_rdy = (state_q == ST_LOAD);
    assign o_vsync  = sb4_q[3];
    assign o_hsync  = sb4_q[2];
    assign o_reuse  = sb4_q[1];
    assign o_valid  = sb4_q[0];
    assign o_tdata  = tdata_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_multi_thread_l1.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_multi_thread_l1
// Description : Directed bench; four shared-stimulus instances cover ReLU on/off
//               and wide/narrow (saturating) outputs.
// Revision    : 1.0
// ============================================================================
module tb_conv_multi_thread_l1;

    localparam int NK = 9;

    logic        clk = 1'b0;
    logic        rst_n, vsync, hsync, reuse, valid, cw_vld;
    logic [71:0] tdata;
    logic [19:0] cw;

    logic        rdy_a, vs_a, hs_a, ru_a, vl_a;
    logic        rdy_b, vs_b, hs_b, ru_b, vl_b;
    logic        rdy_c, vs_c, hs_c, ru_c, vl_c;
    logic        rdy_d, vs_d, hs_d, ru_d, vl_d;
    logic [53:0] td_a, td_b;
    logic [11:0] td_c, td_d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_multi_thread_l1 #(.WIDTH_D(8), .CH(1), .LEN(3), .WIDTH_W(20), .WIDTH_C(27),
                           .THREAD(2), .QUANT_D(2), .RELU_EN(1)) u_a (
        .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_reuse(reuse),
        .i_valid(valid), .i_tdata(tdata), .i_cw_vld(cw_vld), .i_cw(cw), .o_cw_rdy(rdy_a),
        .o_vsync(vs_a), .o_hsync(hs_a), .o_reuse(ru_a), .o_valid(vl_a), .o_tdata(td_a));

    conv_multi_thread_l1 #(.WIDTH_D(8), .CH(1), .LEN(3), .WIDTH_W(20), .WIDTH_C(27),
                           .THREAD(2), .QUANT_D(2), .RELU_EN(0)) u_b (
        .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_reuse(reuse),
        .i_valid(valid), .i_tdata(tdata), .i_cw_vld(cw_vld), .i_cw(cw), .o_cw_rdy(rdy_b),
        .o_vsync(vs_b), .o_hsync(hs_b), .o_reuse(ru_b), .o_valid(vl_b), .o_tdata(td_b));

    conv_multi_thread_l1 #(.WIDTH_D(8), .CH(1), .LEN(3), .WIDTH_W(20), .WIDTH_C(6),
                           .THREAD(2), .QUANT_D(2), .RELU_EN(1)) u_c (
        .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_reuse(reuse),
        .i_valid(valid), .i_tdata(tdata), .i_cw_vld(cw_vld), .i_cw(cw), .o_cw_rdy(rdy_c),
        .o_vsync(vs_c), .o_hsync(hs_c), .o_reuse(ru_c), .o_valid(vl_c), .o_tdata(td_c));

    conv_multi_thread_l1 #(.WIDTH_D(8), .CH(1), .LEN(3), .WIDTH_W(20), .WIDTH_C(6),
                           .THREAD(2), .QUANT_D(2), .RELU_EN(0)) u_d (
        .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_hsync(hsync), .i_reuse(reuse),
        .i_valid(valid), .i_tdata(tdata), .i_cw_vld(cw_vld), .i_cw(cw), .o_cw_rdy(rdy_d),
        .o_vsync(vs_d), .o_hsync(hs_d), .o_reuse(ru_d), .o_valid(vl_d), .o_tdata(td_d));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint th27(input logic [53:0] v, input int t);
        logic [26:0] x;
        x = v[27*t +: 27];
        return longint'($signed(x));
    endfunction

    function automatic longint th6(input logic [11:0] v, input int t);
        logic [5:0] x;
        x = v[6*t +: 6];
        return longint'($signed(x));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input longint a0, input longint a1,
                             input longint b0, input longint b1, input longint c0,
                             input longint c1, input longint d0, input longint d1);
        check_eq({tag, "_a0"}, th27(td_a, 0), a0);
        check_eq({tag, "_a1"}, th27(td_a, 1), a1);
        check_eq({tag, "_b0"}, th27(td_b, 0), b0);
        check_eq({tag, "_b1"}, th27(td_b, 1), b1);
        check_eq({tag, "_c0"}, th6(td_c, 0), c0);
        check_eq({tag, "_c1"}, th6(td_c, 1), c1);
        check_eq({tag, "_d0"}, th6(td_d, 0), d0);
        check_eq({tag, "_d1"}, th6(td_d, 1), d1);
    endtask

    // Word i goes to thread 0 for i < NK, else thread 1.
    task automatic load_words(input int start, input int n, input int w0, input int w1);
        for (int i = start; i < start + n; i++) begin
            cw_vld = 1'b1;
            cw     = (i < NK) ? 20'(w0) : 20'(w1);
            tick();
        end
        cw_vld = 1'b0;
        cw     = '0;
    endtask

    task automatic vsync_pulse();
        int lat;
        lat   = 0;
        vsync = 1'b1;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            tick();
            vsync = 1'b0;
            if (vs_a) lat = c;
        end
        check_eq("vsync_latency", lat, 4);
    endtask

    task automatic run_window(input logic [7:0] pix);
        int lat;
        lat = 0;
        for (int k = 0; k < NK; k++) tdata[8*k +: 8] = pix;
        valid = 1'b1;
        hsync = 1'b1;
        reuse = 1'b1;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            tick();
            valid = 1'b0;
            hsync = 1'b0;
            reuse = 1'b0;
            if (vl_a) lat = c;
        end
        check_eq("valid_latency", lat, 4);
        check_eq("hsync_follow", hs_a, 1);
        check_eq("reuse_follow", ru_a, 1);
        check_eq("valid_all", {vl_b, vl_c, vl_d}, 3'b111);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b1;
        vsync  = 1'b0;
        hsync  = 1'b0;
        reuse  = 1'b0;
        valid  = 1'b0;
        cw_vld = 1'b0;
        cw     = '0;
        tdata  = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", vl_a, 0);
        check_eq("rst_vsync", vs_a, 0);
        check_eq("rst_rdy", rdy_a, 1);
        check_eq("rst_tdata_a", td_a, 0);
        rst_n = 1'b1;
        tick();

        // Zero banks before any swap
        run_window(8'd4);
        check_out("zero_bank", 0, 0, 0, 0, 0, 0, 0, 0);

        // All-ones weights; words offered while FULL must be ignored
        load_words(0, 17, 1, 1);
        check_eq("rdy_before_last", rdy_a, 1);
        load_words(17, 1, 1, 1);
        check_eq("rdy_full", rdy_a, 0);
        cw_vld = 1'b1;
        cw     = 20'd7;
        tick();
        tick();
        check_eq("rdy_full_hold", rdy_a, 0);
        cw_vld = 1'b0;
        vsync_pulse();
        check_eq("rdy_after_swap", rdy_a, 1);
        run_window(8'd4);
        check_out("ones", 9, 9, 9, 9, 9, 9, 9, 9);

        // Thread 0 negative, thread 1 positive
        load_words(0, 18, -1, 1);
        vsync_pulse();
        run_window(8'd4);
        check_out("signs", 0, 9, -9, 9, 0, 9, -9, 9);
        tick();
        tick();
        tick();
        check_eq("hold_valid", vl_a, 0);
        check_eq("hold_a1", th27(td_a, 1), 9);
        check_eq("hold_b0", th27(td_b, 0), -9);

        // Saturation on the narrow instances
        load_words(0, 18, 100, 100);
        vsync_pulse();
        run_window(8'd255);
        check_out("sat_pos", 57375, 57375, 57375, 57375, 31, 31, 31, 31);
        load_words(0, 18, -100, -100);
        vsync_pulse();
        run_window(8'd255);
        check_out("sat_neg", 0, 0, -57375, -57375, 0, 0, -32, -32);

        // Partial load: vsync must not swap, and the count must resume
        load_words(0, 10, 2, 2);
        vsync_pulse();
        check_eq("rdy_partial", rdy_a, 1);
        run_window(8'd4);
        check_out("partial_old", 0, 0, -900, -900, 0, 0, -32, -32);
        load_words(10, 8, 2, 2);
        check_eq("rdy_partial_full", rdy_a, 0);
        vsync_pulse();
        run_window(8'd4);
        check_out("partial_new", 18, 18, 18, 18, 18, 18, 18, 18);

        // Last word coincides with the vsync rise: no swap this frame
        load_words(0, 17, 3, 3);
        cw_vld = 1'b1;
        cw     = 20'd3;
        vsync  = 1'b1;
        tick();
        cw_vld = 1'b0;
        vsync  = 1'b0;
        check_eq("rdy_last_on_vsync", rdy_a, 0);
        tick();
        run_window(8'd4);
        check_out("late_word_old", 18, 18, 18, 18, 18, 18, 18, 18);
        vsync_pulse();
        run_window(8'd4);
        check_out("late_word_new", 27, 27, 27, 27, 27, 27, 27, 27);

        // Asynchronous reset with o_valid high and a partial load pending
        load_words(0, 5, 1, 1);
        for (int k = 0; k < NK; k++) tdata[8*k +: 8] = 8'd4;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("pre_rst_valid", vl_a, 1);
        check_eq("pre_rst_a0", th27(td_a, 0), 27);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", vl_a, 0);
        check_eq("async_rst_rdy", rdy_a, 1);
        check_eq("async_rst_tdata", td_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_window(8'd4);
        check_out("post_rst_zero", 0, 0, 0, 0, 0, 0, 0, 0);
        load_words(0, 17, 1, 1);
        check_eq("post_rst_rdy17", rdy_a, 1);
        load_words(17, 1, 1, 1);
        check_eq("post_rst_rdy18", rdy_a, 0);
        vsync_pulse();
        run_window(8'd4);
        check_out("post_rst_ones", 9, 9, 9, 9, 9, 9, 9, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
